// File: rtl/rv32i_control_fsm_if.sv
// rv32i_control_fsm_if: opcode/memory handshake inputs and datapath control outputs of the sequencer.
interface rv32i_control_fsm_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic       pc_we;
  logic       ir_we;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       pc_sel;
  logic       alu_a_sel;
  logic       alu_b_sel;
  logic [2:0] state;
  logic       bus_error;
  logic       illegal_instr;
  modport master (
    input  opcode, mem_ready, branch_taken,
    output pc_we, ir_we, mem_req, mem_we, mem_addr_sel, rf_we, wb_sel,
           pc_sel, alu_a_sel, alu_b_sel, state, bus_error, illegal_instr
  );
  modport slave (
    output opcode, mem_ready, branch_taken,
    input  pc_we, ir_we, mem_req, mem_we, mem_addr_sel, rf_we, wb_sel,
           pc_sel, alu_a_sel, alu_b_sel, state, bus_error, illegal_instr
  );
endinterface

// File: rtl/rv32i_control_fsm.sv
// rv32i_control_fsm: multi-cycle RV32I sequencer with shared memory port and timeout watchdog.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes; otherwise they execute as NOP.
module rv32i_control_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  rv32i_control_fsm_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
    OP_ST = 7'b0100011, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111, OP_BR = 7'b1100011,
    OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;
  logic          illegal_d;
  logic          is_ld, is_st, timeout;
  assign is_ld     = bus.opcode == OP_LD;
  assign is_st     = bus.opcode == OP_ST;
  assign timeout   = cnt_q == CW'(MEM_TIMEOUT - 1);
  assign bus.state = state_q;
  assign bus.bus_error = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign bus.illegal_instr = illegal_q;
`else
  assign bus.illegal_instr = 1'b0;
`endif
  always_comb begin
    state_d          = state_q;
    cnt_d            = '0;
    bus_err_d        = bus_err_q;
    illegal_d        = bus.illegal_instr;
    bus.pc_we        = 1'b0;
    bus.ir_we        = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.rf_we        = 1'b0;
    bus.wb_sel       = 2'b00;
    bus.pc_sel       = 1'b0;
    bus.alu_a_sel    = 1'b0;
    bus.alu_b_sel    = 1'b0;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.ir_we   = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE:
        case (bus.opcode)
          OP_R:   state_d = S_WB;
          OP_I, OP_AUI: begin
            bus.alu_a_sel = bus.opcode == OP_AUI;
            bus.alu_b_sel = 1'b1;
            state_d       = S_WB;
          end
          OP_LD, OP_ST: begin
            bus.alu_b_sel = 1'b1;
            state_d       = S_MEM;
          end
          OP_LUI: state_d = S_WB;
          OP_BR, OP_JAL, OP_JALR: begin
            bus.pc_we     = 1'b1;
            bus.pc_sel    = bus.opcode == OP_BR ? bus.branch_taken : 1'b1;
            bus.rf_we     = bus.opcode != OP_BR;
            bus.wb_sel    = bus.opcode == OP_BR ? 2'b00 : 2'b10;
            bus.alu_a_sel = bus.opcode != OP_JALR;
            bus.alu_b_sel = 1'b1;
            state_d       = S_FETCH;
          end
          default: begin
`ifdef ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
            state_d   = S_TRAP;
`else
            bus.pc_we = 1'b1;
            state_d   = S_FETCH;
`endif
          end
        endcase
      S_MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.alu_b_sel    = 1'b1;
        bus.mem_we       = is_st;
        bus.pc_we        = bus.mem_ready && is_st;
        if (bus.mem_ready) state_d = is_st ? S_FETCH : S_WB;
      end
      S_WB: begin
        bus.rf_we  = 1'b1;
        bus.pc_we  = 1'b1;
        bus.wb_sel = is_ld ? 2'b01 : bus.opcode == OP_LUI ? 2'b11 : 2'b00;
        state_d    = S_FETCH;
      end
      default: state_d = state_q;
    endcase
    // mem_ready is checked first, so a completion on the last allowed cycle still wins
    if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready) begin
      if (timeout) begin
        state_d   = S_HALT;
        bus_err_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) illegal_q <= 1'b0;
    else illegal_q <= illegal_d;
`endif
endmodule

// File: tb/tb_rv32i_control_fsm.sv
// tb_rv32i_control_fsm: directed checks of state sequence, control outputs and watchdog.
module tb_rv32i_control_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  rv32i_control_fsm_if bus ();
  rv32i_control_fsm #(.MEM_TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [10:0] ctrl;
  assign ctrl = {bus.pc_we, bus.ir_we, bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.rf_we,
                 bus.wb_sel, bus.pc_sel, bus.alu_a_sel, bus.alu_b_sel};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [2:0] st, input logic [10:0] c);
    #1;
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".ctrl"}, 32'(ctrl), 32'(c));
    @(negedge clk);
  endtask
  task automatic front(input string tag, input logic [6:0] op);
    bus.opcode    = op;
    bus.mem_ready = 1'b1;
    cyc({tag, "_f"}, 3'd1, 11'b0_1_1_0_0_0_00_0_0_0);
    cyc({tag, "_d"}, 3'd2, 11'b0_0_0_0_0_0_00_0_0_0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc("rst_rel", 3'd0, 11'd0);
  endtask
  initial begin
    bus.opcode       = 7'b0110011;
    bus.mem_ready    = 1'b1;
    bus.branch_taken = 1'b0;
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_buserr", 32'(bus.bus_error), 32'd0);
    chk("rst_illegal", 32'(bus.illegal_instr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("rst_rel", 3'd0, 11'd0);
    front("r", 7'b0110011);
    cyc("r_e", 3'd3, 11'b0_0_0_0_0_0_00_0_0_0);
    cyc("r_wb", 3'd5, 11'b1_0_0_0_0_1_00_0_0_0);
    front("ld", 7'b0000011);
    cyc("ld_e", 3'd3, 11'b0_0_0_0_0_0_00_0_0_1);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ld_mwait", 3'd4, 11'b0_0_1_0_1_0_00_0_0_1);
    bus.mem_ready = 1'b1;
    cyc("ld_m", 3'd4, 11'b0_0_1_0_1_0_00_0_0_1);
    cyc("ld_wb", 3'd5, 11'b1_0_0_0_0_1_01_0_0_0);
    front("st", 7'b0100011);
    cyc("st_e", 3'd3, 11'b0_0_0_0_0_0_00_0_0_1);
    cyc("st_m", 3'd4, 11'b1_0_1_1_1_0_00_0_0_1);
    bus.branch_taken = 1'b1;
    front("bt", 7'b1100011);
    cyc("bt_e", 3'd3, 11'b1_0_0_0_0_0_00_1_1_1);
    bus.branch_taken = 1'b0;
    front("bn", 7'b1100011);
    cyc("bn_e", 3'd3, 11'b1_0_0_0_0_0_00_0_1_1);
    front("jal", 7'b1101111);
    cyc("jal_e", 3'd3, 11'b1_0_0_0_0_1_10_1_1_1);
    front("jalr", 7'b1100111);
    cyc("jalr_e", 3'd3, 11'b1_0_0_0_0_1_10_1_0_1);
    front("lui", 7'b0110111);
    cyc("lui_e", 3'd3, 11'b0_0_0_0_0_0_00_0_0_0);
    cyc("lui_wb", 3'd5, 11'b1_0_0_0_0_1_11_0_0_0);
    front("aui", 7'b0010111);
    cyc("aui_e", 3'd3, 11'b0_0_0_0_0_0_00_0_1_1);
    cyc("aui_wb", 3'd5, 11'b1_0_0_0_0_1_00_0_0_0);
    front("ii", 7'b0010011);
    cyc("ii_e", 3'd3, 11'b0_0_0_0_0_0_00_0_0_1);
    cyc("ii_wb", 3'd5, 11'b1_0_0_0_0_1_00_0_0_0);
    bus.opcode = 7'b0000011;
    cyc("async_f", 3'd1, 11'b0_1_1_0_0_0_00_0_0_0);
    #3 rst = 1'b1;
    #1;
    chk("async_state", 32'(bus.state), 32'd0);
    chk("async_ctrl", 32'(ctrl), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("async_rel", 3'd0, 11'd0);
    front("ill", 7'b1111111);
`ifdef ILLEGAL_TRAP_EN
    cyc("ill_e", 3'd3, 11'b0_0_0_0_0_0_00_0_0_0);
    cyc("ill_trap", 3'd7, 11'd0);
    cyc("ill_trap2", 3'd7, 11'd0);
    chk("ill_flag", 32'(bus.illegal_instr), 32'd1);
`else
    cyc("ill_e", 3'd3, 11'b1_0_0_0_0_0_00_0_0_0);
    cyc("ill_next", 3'd1, 11'b0_1_1_0_0_0_00_0_0_0);
    chk("ill_flag", 32'(bus.illegal_instr), 32'd0);
`endif
    do_reset();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc("to_wait", 3'd1, 11'b0_0_1_0_0_0_00_0_0_0);
    cyc("to_halt", 3'd6, 11'd0);
    chk("to_buserr", 32'(bus.bus_error), 32'd1);
    bus.mem_ready = 1'b1;
    cyc("to_halt_hold", 3'd6, 11'd0);
    chk("to_buserr_hold", 32'(bus.bus_error), 32'd1);
    do_reset();
    chk("to_buserr_clr", 32'(bus.bus_error), 32'd0);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc("win_wait", 3'd1, 11'b0_0_1_0_0_0_00_0_0_0);
    bus.mem_ready = 1'b1;
    cyc("win_f", 3'd1, 11'b0_1_1_0_0_0_00_0_0_0);
    cyc("win_d", 3'd2, 11'd0);
    chk("win_buserr", 32'(bus.bus_error), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
